mem_dp_param: RTL

Parametrised one-read/one-write memory that replaces the fixed 5-bit × 8-word memory in the FIFO data path. It adds configurable width, depth and read latency, plus a read-valid/read-error handshake. It tracks which words have been written, forwards data for same-cycle read/write collisions, and reports occupancy. FIFO controllers instantiate it as their storage element.

---
 rtl/mem_dp_param_pkg.sv | 26 ++
 rtl/mem_dp_param_if.sv | 34 +++
 rtl/mem_dp_param_rd_pipe.sv | 57 +++++
 rtl/mem_dp_param.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_dp_param_pkg.sv
// rtl/mem_dp_param_pkg.sv - shared constants and record types for mem_dp_param
//
// Package mem_pkg:
//   MEM_LAT_MIN / MEM_LAT_MAX  legal read latencies
//   MEM_DATA_W_MAX             widest word the stage-1 record can carry
//   mem_rd_res_t               stage-1 read result {valid, err, data}
//   mem_lat_ok()               latency legality check used at elaboration
package mem_pkg;

  localparam int MEM_LAT_MIN    = 1;
  localparam int MEM_LAT_MAX    = 2;
  localparam int MEM_DATA_W_MAX = 32;

  // Data is carried at the widest supported size; instances use the low DATA_W bits
  // and keep the rest at zero.
  typedef struct packed {
    logic                      valid;
    logic                      err;
    logic [MEM_DATA_W_MAX-1:0] data;
  } mem_rd_res_t;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_dp_param_if.sv
// rtl/mem_dp_param_if.sv - read/write request and response bundle for mem_dp_param
//
// Signals:
//   write_rq, w_address, write_data   write request (master -> slave)
//   read_rq, r_address                read request (master -> slave)
//   read_data, read_valid, read_err   read response (slave -> master)
//   words_used                        occupancy count (slave -> master)
// Modports: master (requester), slave (memory).
interface mem_dp_param_if #(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 4
);

  logic              write_rq;
  logic [ADDR_W-1:0] w_address;
  logic [DATA_W-1:0] write_data;
  logic              read_rq;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              read_err;
  logic [ADDR_W:0]   words_used;

  modport master (
    output write_rq, w_address, write_data, read_rq, r_address,
    input  read_data, read_valid, read_err, words_used
  );

  modport slave (
    input  write_rq, w_address, write_data, read_rq, r_address,
    output read_data, read_valid, read_err, words_used
  );

endinterface

// File: rtl/mem_dp_param_rd_pipe.sv
// rtl/mem_dp_param_rd_pipe.sv - optional second output register for the read path
//
// Module mem_rd_pipe:
//   clk, rst                      clock, asynchronous active-low reset (stage clears to 0)
//   in_valid, in_err, in_data     stage-1 read result
//   out_valid, out_err, out_data  result presented to the memory outputs
// ENABLE=1 adds one register stage; ENABLE=0 passes the input straight through.
module mem_rd_pipe #(
  parameter int DATA_W = 5,
  parameter bit ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (ENABLE) begin : g_reg
      logic              valid_q;
      logic              err_q;
      logic [DATA_W-1:0] data_q;

      // Data only advances with a valid result so the output holds between reads;
      // err is qualified by valid so it reads 0 whenever no result is presented.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= in_valid;
          err_q   <= in_valid & in_err;
          if (in_valid) begin
            data_q <= in_data;
          end
        end
      end

      assign out_valid = valid_q;
      assign out_err   = err_q;
      assign out_data  = data_q;
    end else begin : g_thru
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign out_valid = in_valid;
      assign out_err   = in_err;
      assign out_data  = in_data;
    end
  endgenerate

endmodule

// File: rtl/mem_dp_param.sv
// rtl/mem_dp_param.sv - parametrised 1R/1W memory with written-tracking and occupancy
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   mem_dp_param_if.slave: write/read requests, read_data/read_valid/read_err,
//         words_used
// Parameters: DATA_W, ADDR_W, DEPTH (1..2**ADDR_W), RD_LAT (1 or 2).
// Build option MEM_BYPASS_EN: defined -> write-first forwarding on a same-address
// read/write collision; undefined -> read-first (pre-write content and status).
module mem_dp_param
  import mem_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_dp_param_if.slave  bus
);

  generate
    if (!mem_lat_ok(RD_LAT)) begin : g_bad_lat
      $error("mem_dp_param: RD_LAT must be 1 or 2");
    end
    if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_bad_depth
      $error("mem_dp_param: DEPTH must be in 1..2**ADDR_W");
    end
    if ((DATA_W < 1) || (DATA_W > MEM_DATA_W_MAX)) begin : g_bad_width
      $error("mem_dp_param: DATA_W out of range");
    end
  endgenerate

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic [ADDR_W:0]   used;

  logic              w_ok;
  logic              r_in;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;

  mem_rd_res_t       s1_next;
  mem_rd_res_t       s1;

  // Addresses are range-checked on the full width before the narrow index is used,
  // so the truncated index never reaches an unimplemented word.
  assign w_ok = bus.write_rq && ({1'b0, bus.w_address} < DEPTH_L);
  assign r_in = {1'b0, bus.r_address} < DEPTH_L;
  assign widx = bus.w_address[IDX_W-1:0];
  assign ridx = bus.r_address[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (w_ok) begin
      mem[widx] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written <= '0;
      used    <= '0;
    end else if (w_ok) begin
      written[widx] <= 1'b1;
      if (!written[widx]) begin
        used <= used + (ADDR_W + 1)'(1);
      end
    end
  end

  // Stage-1 result. Array and written bits are sampled before this edge's write
  // lands, which is the read-first collision behaviour without extra logic.
  always_comb begin
    s1_next       = '0;
    s1_next.valid = bus.read_rq;
    if (bus.read_rq) begin
      if (r_in && written[ridx]) begin
        s1_next.data[DATA_W-1:0] = mem[ridx];
      end else begin
        s1_next.err = 1'b1;
      end
`ifdef MEM_BYPASS_EN
      if (w_ok && r_in && (bus.r_address == bus.w_address)) begin
        s1_next.data                = '0;
        s1_next.data[DATA_W-1:0]    = bus.write_data;
        s1_next.err                 = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= s1_next.valid;
      s1.err   <= s1_next.err;
      if (bus.read_rq) begin
        s1.data <= s1_next.data;
      end
    end
  end

  generate
    if (DATA_W < MEM_DATA_W_MAX) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^s1.data[MEM_DATA_W_MAX-1:DATA_W];
    end
  endgenerate

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .ENABLE (RD_LAT == MEM_LAT_MAX)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1.valid),
    .in_err    (s1.err),
    .in_data   (s1.data[DATA_W-1:0]),
    .out_valid (bus.read_valid),
    .out_err   (bus.read_err),
    .out_data  (bus.read_data)
  );

  assign bus.words_used = used;

endmodule
